hnf_rxchnl_pocq: RTL and testbench

Parametrised CHI receive-channel front end for the HN-F. It generalises the fixed RXREQ receiver to any flit width, queue depth and link-credit budget, and adds link-deactivation credit return and protocol-error detection. Accepted flits go into a first-word-fall-through POCQ whose head entry is presented to the downstream pipeline with a valid/pop handshake. It sits between the CHI link layer and the HN-F request pipeline, one instance per RX channel.

---
 rtl/hnf_rxchnl_pocq.sv | 224 ++++++++++++++++++++++
 tb/tb_hnf_rxchnl_pocq.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hnf_rxchnl_pocq.sv
// ---------------------------------------------------------------------------
// hnf_chi_req_pkg / hnf_rxchnl_pocq
//
// CHI receive-channel front end for the HN-F. The module handles one RX
// channel. It issues link credits, accepts flits against those credits, and
// holds accepted flits in a first-word-fall-through POCQ. The head of the
// queue is offered to the request pipeline with a valid/pop handshake. While
// the link is down no new credits are granted. Outstanding credits come back
// either as normal flits or as LCrdReturn flits. A flit that arrives with no
// credit outstanding sets a sticky protocol-error flag.
//
// Parameters
//   FLIT_W    flit payload width (default: REQ flit width)
//   DEPTH     POCQ entries, power of two, 2..64
//   MAX_LCRD  maximum link credits outstanding, 1..15, <= DEPTH
//   CNT_W     occupancy counter width (derived, leave at default)
//
// Ports
//   clk               clock, all state updates on the rising edge
//   rst_n             asynchronous active-low reset
//   rxflit            incoming flit payload
//   rxflitv           incoming flit valid
//   rxflitpend        early-flit hint (advisory, not used)
//   rxflit_is_crdret  the incoming flit is an LCrdReturn
//   rxlcrdv           link-credit grant, one credit per high cycle
//   link_active       link up; credits may be granted
//   link_idle         link down and no credits outstanding (registered)
//   head_v            queue head is valid
//   head_flit         queue head payload
//   head_pop          consumer takes the head (ignored when head_v=0)
//   occupancy         number of queued entries
//   credits_out       credits granted but not yet consumed
//   proto_err         sticky: a flit arrived with no credit outstanding
// ---------------------------------------------------------------------------

package hnf_chi_req_pkg;

    // REQ flit layout as seen by the HN-F request pipeline.
    typedef struct packed {
        logic [3:0]  qos;
        logic [6:0]  tgt_id;
        logic [6:0]  src_id;
        logic [7:0]  txn_id;
        logic [6:0]  return_nid;
        logic [7:0]  return_txn_id;
        logic [5:0]  opcode;
        logic [2:0]  size;
        logic [47:0] addr;
        logic        ns;
        logic        likely_shared;
        logic        allow_retry;
        logic [1:0]  order;
        logic [3:0]  p_crd_type;
        logic [3:0]  mem_attr;
        logic        snp_attr;
        logic [4:0]  lp_id;
        logic        excl;
        logic        exp_comp_ack;
        logic        trace_tag;
    } reqflit_t;

endpackage

module hnf_rxchnl_pocq
    import hnf_chi_req_pkg::*;
#(
    parameter int FLIT_W   = $bits(reqflit_t),
    parameter int DEPTH    = 8,
    parameter int MAX_LCRD = 4,
    parameter int CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,

    // link layer side
    input  logic [FLIT_W-1:0] rxflit,
    input  logic              rxflitv,
    input  logic              rxflitpend,
    input  logic              rxflit_is_crdret,
    output logic              rxlcrdv,
    input  logic              link_active,
    output logic              link_idle,

    // request pipeline side
    output logic              head_v,
    output logic [FLIT_W-1:0] head_flit,
    input  logic              head_pop,

    // status
    output logic [CNT_W-1:0]  occupancy,
    output logic [3:0]        credits_out,
    output logic              proto_err
);

    localparam int PTR_W = $clog2(DEPTH);

    // rxflitpend is only an early hint. Nothing in this block needs it.
    logic unused_rxflitpend;
    assign unused_rxflitpend = rxflitpend;

    // -----------------------------------------------------------------------
    // Storage and pointers
    // -----------------------------------------------------------------------
    logic [FLIT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wp;
    logic [PTR_W-1:0]  rp;

    // -----------------------------------------------------------------------
    // Per-cycle events
    // -----------------------------------------------------------------------
    logic flit_accept;   // legal flit: consumes one credit
    logic flit_store;    // legal flit that carries a payload for the queue
    logic flit_illegal;  // flit with no credit outstanding
    logic pop;           // consumer takes a valid head
    logic grant_ok;      // a new credit may be issued on the next cycle

    assign flit_accept  = rxflitv && (credits_out != 4'd0);
    assign flit_store   = flit_accept && !rxflit_is_crdret;
    assign flit_illegal = rxflitv && (credits_out == 4'd0);
    assign pop          = head_pop && head_v;

    // Grants are judged from registered state only. A grant that is on the
    // wire this cycle (rxlcrdv=1) is not yet in credits_out, so it is counted
    // here. Without it, back-to-back grants would overshoot by one. Flits
    // consumed in this cycle only lower the true totals, so ignoring them is
    // conservative. A freed slot therefore shows up one cycle later.
    assign grant_ok = link_active
                   && (int'(credits_out) + int'(rxlcrdv) < MAX_LCRD)
                   && (int'(occupancy) + int'(credits_out) + int'(rxlcrdv) < DEPTH);

    // -----------------------------------------------------------------------
    // Queue payload
    // -----------------------------------------------------------------------
    // NOTE: the payload array has no reset. Entries are only read behind
    // head_v, so clearing them would add reset fan-out and change nothing.
    always_ff @(posedge clk) begin
        if (flit_store) begin
            mem[wp] <= rxflit;
        end
    end

    assign head_v    = (occupancy != '0);
    assign head_flit = mem[rp];

    // -----------------------------------------------------------------------
    // Pointers and occupancy
    // -----------------------------------------------------------------------
    // NOTE: all registered state uses non-blocking assignments. Every
    // always_ff block then sees the values from before the edge, whatever
    // order the blocks are evaluated in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp <= '0;
            rp <= '0;
        end else begin
            // DEPTH is a power of two, so the pointers wrap naturally.
            if (flit_store) begin
                wp <= wp + PTR_W'(1);
            end
            if (pop) begin
                rp <= rp + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occupancy <= '0;
        end else begin
            unique case ({flit_store, pop})
                2'b10:   occupancy <= occupancy + CNT_W'(1);
                2'b01:   occupancy <= occupancy - CNT_W'(1);
                default: occupancy <= occupancy;  // idle, or push+pop together
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Link credits
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxlcrdv <= 1'b0;
        end else begin
            rxlcrdv <= grant_ok;
        end
    end

    // A grant on the wire this cycle becomes an outstanding credit at the
    // edge. A legal flit retires one. When both happen, the count holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credits_out <= 4'd0;
        end else begin
            unique case ({rxlcrdv, flit_accept})
                2'b10:   credits_out <= credits_out + 4'd1;
                2'b01:   credits_out <= credits_out - 4'd1;
                default: credits_out <= credits_out;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Link status and protocol error
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            link_idle <= 1'b0;
        end else begin
            link_idle <= !link_active && (credits_out == 4'd0);
        end
    end

    // The illegal flit itself is dropped. flit_accept is low for it, so no
    // counter or pointer moves. Only reset clears the flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            proto_err <= 1'b0;
        end else if (flit_illegal) begin
            proto_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_hnf_rxchnl_pocq.sv
`timescale 1ns/1ps
module tb_hnf_rxchnl_pocq;

    localparam int FLIT_W   = 16;
    localparam int DEPTH    = 8;
    localparam int MAX_LCRD = 4;
    localparam int CNT_W    = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [FLIT_W-1:0] rxflit = '0;
    logic              rxflitv = 1'b0;
    logic              rxflitpend = 1'b0;
    logic              rxflit_is_crdret = 1'b0;
    logic              rxlcrdv;
    logic              link_active = 1'b0;
    logic              link_idle;
    logic              head_v;
    logic [FLIT_W-1:0] head_flit;
    logic              head_pop = 1'b0;
    logic [CNT_W-1:0]  occupancy;
    logic [3:0]        credits_out;
    logic              proto_err;

    always #5 clk = ~clk;

    hnf_rxchnl_pocq #(
        .FLIT_W   (FLIT_W),
        .DEPTH    (DEPTH),
        .MAX_LCRD (MAX_LCRD)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .rxflit           (rxflit),
        .rxflitv          (rxflitv),
        .rxflitpend       (rxflitpend),
        .rxflit_is_crdret (rxflit_is_crdret),
        .rxlcrdv          (rxlcrdv),
        .link_active      (link_active),
        .link_idle        (link_idle),
        .head_v           (head_v),
        .head_flit        (head_flit),
        .head_pop         (head_pop),
        .occupancy        (occupancy),
        .credits_out      (credits_out),
        .proto_err        (proto_err)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // -----------------------------------------------------------------------
    // Reference model and scoreboard. Each negedge applies the inputs seen
    // at the previous negedge, which are what the edge in between sampled.
    // The model then compares the DUT outputs against its own state.
    // -----------------------------------------------------------------------
    typedef struct {
        bit                valid;
        bit                flitv;
        bit                crdret;
        logic [FLIT_W-1:0] flit;
        bit                pop;
        logic [FLIT_W-1:0] hflit;
        bit                lcrdv;
        bit                link;
    } snap_t;

    logic [FLIT_W-1:0] exp_q[$];
    int                m_tally = 0;   // credits held by the transmitter
    bit                m_proto = 1'b0;
    snap_t             sn = '{default: 0};

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            m_tally = 0;
            m_proto = 1'b0;
            sn.valid = 1'b0;
        end else begin
            int  tally_before;
            bit  exp_idle;
            tally_before = m_tally;
            exp_idle = 1'b0;
            if (sn.valid) begin
                if (sn.pop && exp_q.size() != 0)
                    check("head_flit_pop", sn.hflit, exp_q.pop_front());
                if (sn.flitv) begin
                    if (m_tally > 0) begin
                        m_tally--;
                        if (!sn.crdret) exp_q.push_back(sn.flit);
                    end else begin
                        m_proto = 1'b1;
                    end
                end
                if (sn.lcrdv) m_tally++;
                exp_idle = !sn.link && (tally_before == 0);
            end
            check("occupancy", occupancy, exp_q.size());
            check("credits_out", credits_out, m_tally);
            check("head_v", head_v, exp_q.size() != 0);
            if (exp_q.size() != 0) check("head_flit", head_flit, exp_q[0]);
            check("proto_err", proto_err, m_proto);
            check("link_idle", link_idle, exp_idle);
            check("grant_while_link_down", rxlcrdv && !(sn.valid && sn.link), 0);
            check("credits_bound", credits_out <= MAX_LCRD, 1);
            check("slot_invariant", int'(occupancy) + int'(credits_out) <= DEPTH, 1);

            sn.valid  = 1'b1;
            sn.flitv  = rxflitv;
            sn.crdret = rxflit_is_crdret;
            sn.flit   = rxflit;
            sn.pop    = head_pop;
            sn.hflit  = head_flit;
            sn.lcrdv  = rxlcrdv;
            sn.link   = link_active;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic send_flits(input int n, input int base, output int sent);
        sent = 0;
        for (int c = 0; c < 200 && sent < n; c++) begin
            @(posedge clk); #1;
            if (credits_out != 4'd0) begin
                rxflitv = 1'b1;
                rxflit_is_crdret = 1'b0;
                rxflit = FLIT_W'(base + sent);
                sent++;
            end else begin
                rxflitv = 1'b0;
            end
        end
        @(posedge clk); #1;
        rxflitv = 1'b0;
    endtask

    initial begin
        int n_grant;
        int first;
        int sent;
        int rec[10];
        logic [3:0] c_ref;

        // ---- T1: reset release with the link up ----
        link_active = 1'b1;
        #1;
        check("rst_rxlcrdv", rxlcrdv, 0);
        check("rst_occupancy", occupancy, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        n_grant = 0;
        first = -1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rxlcrdv) begin
                n_grant++;
                if (first < 0) first = i;
            end
        end
        check("t1_grant_count", n_grant, 4);
        check("t1_first_grant_cycle", first, 1);
        check("t1_credits", credits_out, 4);

        // ---- T2: fill with 0x01..0x08, then drain ----
        send_flits(8, 1, sent);
        check("t2_sent", sent, 8);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t2_no_grant_full", rxlcrdv, 0);
        end
        check("t2_full_occ", occupancy, 8);
        check("t2_full_credits", credits_out, 0);
        n_grant = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            head_pop = (i < 8);
            @(negedge clk);
            rec[i] = int'(rxlcrdv);
            if (rxlcrdv) n_grant++;
        end
        head_pop = 1'b0;
        check("t2_no_grant_same_cycle", rec[1], 0);
        check("t2_freed_slot_grant", rec[2], 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (rxlcrdv) n_grant++;
        end
        check("t2_regrant_count", n_grant, 4);
        check("t2_empty_occ", occupancy, 0);
        check("t2_credits", credits_out, 4);

        // ---- T3: steady push+pop at occupancy 1 ----
        @(posedge clk); #1;
        rxflitv = 1'b1;
        rxflit = 16'h0100;
        c_ref = '0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            check("t3_credit_avail", credits_out != 4'd0, 1);
            rxflitv = 1'b1;
            rxflit = FLIT_W'(16'h0101 + i);
            head_pop = 1'b1;
            @(negedge clk);
            check("t3_occ_one", occupancy, 1);
            if (i == 2) c_ref = credits_out;
            if (i > 2) check("t3_credits_const", credits_out, c_ref);
        end
        @(posedge clk); #1;
        rxflitv = 1'b0;
        head_pop = 1'b1;
        @(posedge clk); #1;
        head_pop = 1'b0;
        repeat (8) @(negedge clk);
        check("t3_drained", occupancy, 0);
        check("t3_credits_refill", credits_out, 4);

        // ---- T4: link down, return credits as LCrdReturn ----
        @(posedge clk); #1;
        link_active = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            rxflitv = 1'b1;
            rxflit_is_crdret = 1'b1;
            rxflit = FLIT_W'(16'h00C0 + k);
            @(negedge clk);
            check("t4_no_grant", rxlcrdv, 0);
        end
        @(posedge clk); #1;
        rxflitv = 1'b0;
        rxflit_is_crdret = 1'b0;
        @(negedge clk);
        check("t4_credits_zero", credits_out, 0);
        check("t4_occ_unchanged", occupancy, 0);
        check("t4_idle_not_yet", link_idle, 0);
        @(negedge clk);
        check("t4_link_idle", link_idle, 1);

        // ---- T5: flit with no credit ----
        @(posedge clk); #1;
        rxflitv = 1'b1;
        rxflit = 16'h00EE;
        @(posedge clk); #1;
        rxflitv = 1'b0;
        @(negedge clk);
        check("t5_proto_err", proto_err, 1);
        check("t5_occ_unchanged", occupancy, 0);
        repeat (3) @(negedge clk);
        check("t5_proto_sticky", proto_err, 1);

        // ---- T6: async reset at occupancy 5, credits 3 ----
        @(posedge clk); #1;
        link_active = 1'b1;
        repeat (8) @(negedge clk);
        check("t6_credits_up", credits_out, 4);
        send_flits(5, 16'h0050, sent);
        check("t6_sent", sent, 5);
        repeat (6) @(negedge clk);
        check("t6_pre_occ", occupancy, 5);
        check("t6_pre_credits", credits_out, 3);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("t6_rst_rxlcrdv", rxlcrdv, 0);
        check("t6_rst_head_v", head_v, 0);
        check("t6_rst_occ", occupancy, 0);
        check("t6_rst_credits", credits_out, 0);
        check("t6_rst_proto", proto_err, 0);
        check("t6_rst_idle", link_idle, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // ---- T7: randomized traffic against the model ----
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            if ($urandom_range(0, 99) < 3) link_active = ~link_active;
            rxflitv = (credits_out != 4'd0) && ($urandom_range(0, 99) < 60);
            rxflit_is_crdret = ($urandom_range(0, 5) == 0);
            rxflit = FLIT_W'($urandom);
            rxflitpend = 1'($urandom_range(0, 1));
            head_pop = ($urandom_range(0, 99) < 50);
        end
        @(posedge clk); #1;
        rxflitv = 1'b0;
        link_active = 1'b1;
        head_pop = 1'b1;
        repeat (12) @(posedge clk);
        #1 head_pop = 1'b0;
        repeat (3) @(negedge clk);
        check("final_drained", occupancy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
